fm_hop_sched: RTL and testbench

Frequency-hopping scheduler that configures the FM modulator's carrier word (kc) and peak-deviation word (k_max). It holds a small table of hop entries (kc, k_max, dwell), steps through them under a start/stop handshake, and holds each entry for its dwell time. It sits between the control/register interface and the FM modulator, replacing static kc/k_max drive.

---
 rtl/fm_ctrl_pkg.sv | 24 ++
 rtl/fm_hop_table.sv | 50 +++++
 rtl/fm_hop_sched.sv | 177 +++++++++++++++++
 tb/tb_fm_hop_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fm_ctrl_pkg
// Description : Shared types and default widths for the FM hop scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package fm_ctrl_pkg;

    localparam int C_W  = 32;
    localparam int C_DW = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [C_W-1:0]  kc;
        logic [C_W-1:0]  kmax;
        logic [C_DW-1:0] dwell;
    } hop_entry_t;

endpackage
`default_nettype wire

// File: rtl/fm_hop_table.sv
`default_nettype none
// ============================================================================
// Module      : fm_hop_table
// Description : Hop entry register file, synchronous write and clear,
//               combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module fm_hop_table #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_kc,
    input  logic [W-1:0]  wr_kmax,
    input  logic [DW-1:0] wr_dwell,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_kc,
    output logic [W-1:0]  rd_kmax,
    output logic [DW-1:0] rd_dwell
);

    logic [W-1:0]  r_kc    [DEPTH];
    logic [W-1:0]  r_kmax  [DEPTH];
    logic [DW-1:0] r_dwell [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_kc[i]    <= '0;
                r_kmax[i]  <= '0;
                r_dwell[i] <= '0;
            end
        end else if (we) begin
            r_kc[wr_addr]    <= wr_kc;
            r_kmax[wr_addr]  <= wr_kmax;
            r_dwell[wr_addr] <= wr_dwell;
        end
    end

    assign rd_kc    = r_kc[rd_addr];
    assign rd_kmax  = r_kmax[rd_addr];
    assign rd_dwell = r_dwell[rd_addr];

endmodule
`default_nettype wire

// File: rtl/fm_hop_sched.sv
`default_nettype none
// ============================================================================
// Module      : fm_hop_sched
// Description : Frequency-hopping scheduler driving FM modulator kc / k_max
//               from a programmable hop table with per-entry dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module fm_hop_sched
    import fm_ctrl_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_kc,
    input  logic [W-1:0]  cfg_kmax,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [AW:0]   num_hops,
    input  logic          loop_en,
    input  logic [W-1:0]  idle_kc,
    input  logic          start,
    input  logic          stop,
    output logic [W-1:0]  kc_out,
    output logic [W-1:0]  k_max_out,
    output logic [AW-1:0] hop_idx,
    output logic          hop_strobe,
    output logic          busy,
    output logic          done,
    output logic          cfg_err
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [DW-1:0] r_cnt, w_cnt_nxt;
    logic [AW:0]   r_num, w_num_nxt;
    logic [W-1:0]  r_kc, w_kc_nxt;
    logic [W-1:0]  r_kmax, w_kmax_nxt;
    logic          r_strobe, w_strobe_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_err, w_err_nxt;

    logic          w_tbl_we;
    logic          w_last;
    logic          w_byp;
    logic          w_start_ok;
    logic [AW-1:0] w_rd_addr;
    logic [W-1:0]  w_rd_kc, w_rd_kmax, w_ent_kc, w_ent_kmax;
    logic [DW-1:0] w_rd_dwell, w_ent_dwell, w_ent_cnt;

    assign w_tbl_we   = cfg_we && (r_state == ST_IDLE);
    assign w_last     = ({1'b0, r_idx} == (r_num - 1'b1));
    assign w_rd_addr  = (r_state == ST_RUN && !w_last) ? r_idx + 1'b1 : '0;
    assign w_start_ok = start && !stop && (num_hops != '0) && (num_hops <= C_DEPTH);

    fm_hop_table #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .we       (w_tbl_we),
        .wr_addr  (cfg_addr),
        .wr_kc    (cfg_kc),
        .wr_kmax  (cfg_kmax),
        .wr_dwell (cfg_dwell),
        .rd_addr  (w_rd_addr),
        .rd_kc    (w_rd_kc),
        .rd_kmax  (w_rd_kmax),
        .rd_dwell (w_rd_dwell)
    );

    // A write landing on the entry being launched this cycle must be seen
    // by the new sequence, so forward it around the register file.
    assign w_byp       = w_tbl_we && (cfg_addr == w_rd_addr);
    assign w_ent_kc    = w_byp ? cfg_kc    : w_rd_kc;
    assign w_ent_kmax  = w_byp ? cfg_kmax  : w_rd_kmax;
    assign w_ent_dwell = w_byp ? cfg_dwell : w_rd_dwell;
    assign w_ent_cnt   = (w_ent_dwell == '0) ? '0 : w_ent_dwell - 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_nxt    = r_cnt;
        w_num_nxt    = r_num;
        w_kc_nxt     = r_kc;
        w_kmax_nxt   = r_kmax;
        w_busy_nxt   = r_busy;
        w_strobe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_kc_nxt   = idle_kc;
                w_kmax_nxt = '0;
                w_idx_nxt  = '0;
                w_busy_nxt = 1'b0;
                if (w_start_ok) begin
                    w_state_nxt  = ST_RUN;
                    w_kc_nxt     = w_ent_kc;
                    w_kmax_nxt   = w_ent_kmax;
                    w_cnt_nxt    = w_ent_cnt;
                    w_num_nxt    = num_hops;
                    w_strobe_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                end else if (start && !stop) begin
                    w_err_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                w_err_nxt = cfg_we;
                if (stop || (r_cnt == '0 && w_last && !loop_en)) begin
                    w_state_nxt = ST_IDLE;
                    w_kc_nxt    = idle_kc;
                    w_kmax_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = !stop;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_idx_nxt    = w_rd_addr;
                    w_kc_nxt     = w_ent_kc;
                    w_kmax_nxt   = w_ent_kmax;
                    w_cnt_nxt    = w_ent_cnt;
                    w_strobe_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_num    <= '0;
            r_kc     <= '0;
            r_kmax   <= '0;
            r_strobe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_num    <= w_num_nxt;
            r_kc     <= w_kc_nxt;
            r_kmax   <= w_kmax_nxt;
            r_strobe <= w_strobe_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign kc_out     = r_kc;
    assign k_max_out  = r_kmax;
    assign hop_idx    = r_idx;
    assign hop_strobe = r_strobe;
    assign busy       = r_busy;
    assign done       = r_done;
    assign cfg_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fm_hop_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fm_hop_sched
// Description : Scoreboard bench for fm_hop_sched against a hop-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fm_hop_sched;
    import fm_ctrl_pkg::*;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst, cfg_we, loop_en, start, stop;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_kc, cfg_kmax, idle_kc;
    logic [DW-1:0] cfg_dwell;
    logic [AW:0]   num_hops;
    logic [W-1:0]  kc_out, k_max_out;
    logic [AW-1:0] hop_idx;
    logic          hop_strobe, busy, done, cfg_err;

    always #5 clk = ~clk;

    fm_hop_sched #(.W(W), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_kc     (cfg_kc),
        .cfg_kmax   (cfg_kmax),
        .cfg_dwell  (cfg_dwell),
        .num_hops   (num_hops),
        .loop_en    (loop_en),
        .idle_kc    (idle_kc),
        .start      (start),
        .stop       (stop),
        .kc_out     (kc_out),
        .k_max_out  (k_max_out),
        .hop_idx    (hop_idx),
        .hop_strobe (hop_strobe),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    typedef struct {
        logic [W-1:0]  kc;
        logic [W-1:0]  kmax;
        logic [AW-1:0] idx;
        logic          strobe, busy, done, err;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;

    // Reference model: table plus "which hop, how many cycles still to show".
    hop_entry_t tbl[DEPTH];
    bit         m_run  = 0;
    int         m_pos  = 0;
    int         m_left = 0;
    int         m_n    = 0;

    function automatic int eff(logic [DW-1:0] d);
        return (d == 0) ? 1 : int'(d);
    endfunction

    task automatic model_push();
        exp_t e;
        e.kc = '0; e.kmax = '0; e.idx = '0;
        e.strobe = 0; e.busy = 0; e.done = 0; e.err = 0;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
            m_run = 0;
        end else if (!m_run) begin
            if (cfg_we) tbl[cfg_addr] = '{kc: cfg_kc, kmax: cfg_kmax, dwell: cfg_dwell};
            if (start && !stop && num_hops >= 1 && num_hops <= DEPTH) begin
                m_run = 1; m_pos = 0; m_n = int'(num_hops);
                m_left = eff(tbl[0].dwell);
                e.strobe = 1;
            end else begin
                e.err = start && !stop;
            end
        end else begin
            e.err = cfg_we;
            if (stop) begin
                m_run = 0;
            end else if (m_left > 1) begin
                m_left--;
            end else begin
                if (m_pos < m_n - 1) m_pos++;
                else if (loop_en) m_pos = 0;
                else begin
                    m_run = 0;
                    e.done = 1;
                end
                if (m_run) begin
                    m_left = eff(tbl[m_pos].dwell);
                    e.strobe = 1;
                end
            end
        end
        if (!rst) begin
            if (m_run) begin
                e.kc = tbl[m_pos].kc; e.kmax = tbl[m_pos].kmax;
                e.idx = AW'(m_pos); e.busy = 1;
            end else begin
                e.kc = idle_kc;
            end
        end
        q.push_back(e);
    endtask

    // One clock of stimulus: model sees the inputs the DUT will sample.
    task automatic cyc();
        model_push();
        @(negedge clk);
    endtask

    task automatic write(input int a, input int kc, input int km, input int dw);
        cfg_we = 1; cfg_addr = AW'(a); cfg_kc = W'(kc); cfg_kmax = W'(km); cfg_dwell = DW'(dw);
        cyc();
        cfg_we = 0;
    endtask

    task automatic go(input int n);
        num_hops = (AW+1)'(n); start = 1;
        cyc();
        start = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if ({kc_out, k_max_out, hop_idx, hop_strobe, busy, done, cfg_err} !==
                    {e.kc, e.kmax, e.idx, e.strobe, e.busy, e.done, e.err}) begin
                    failures++;
                    $display("FAIL outputs t=%0t got kc=%0d kmax=%0d idx=%0d stb=%0b busy=%0b done=%0b err=%0b want kc=%0d kmax=%0d idx=%0d stb=%0b busy=%0b done=%0b err=%0b",
                             $time, kc_out, k_max_out, hop_idx, hop_strobe, busy, done, cfg_err,
                             e.kc, e.kmax, e.idx, e.strobe, e.busy, e.done, e.err);
                end
            end
        end
    end

    initial begin : stim
        rst = 1; cfg_we = 0; cfg_addr = '0; cfg_kc = '0; cfg_kmax = '0; cfg_dwell = '0;
        num_hops = '0; loop_en = 0; idle_kc = '0; start = 0; stop = 0;
        cyc(); cyc();
        rst = 0; idle_kc = 1000;
        cyc(); cyc();
        write(0, 500, 50, 3);
        write(1, 800, 80, 2);
        loop_en = 0;
        go(2);
        repeat (8) cyc();
        loop_en = 1;
        go(2);
        repeat (9) cyc();
        stop = 1; cyc(); stop = 0;
        repeat (3) cyc();
        loop_en = 0;
        write(2, 1234, 12, 0);
        go(3);
        repeat (9) cyc();
        go(0); cyc();
        go(9); cyc();
        go(2);
        cfg_we = 1; cfg_addr = 1; cfg_kc = 999; cfg_kmax = 99; cfg_dwell = 2;
        cyc();
        cfg_we = 0;
        repeat (8) cyc();
        start = 1; stop = 1; num_hops = 2; cyc();
        start = 0; stop = 0; cyc();
        // write to entry 0 together with start: the new word must launch
        cfg_we = 1; cfg_addr = 0; cfg_kc = 4242; cfg_kmax = 42; cfg_dwell = 1;
        go(2);
        cfg_we = 0;
        repeat (2) cyc();
        rst = 1; cyc(); rst = 0;
        go(2);
        repeat (5) cyc();

        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            cfg_we   = ($urandom_range(0, 4) == 0);
            cfg_addr = AW'($urandom);
            cfg_kc   = $urandom;
            cfg_kmax = $urandom;
            cfg_dwell = DW'($urandom_range(0, 4));
            num_hops = (AW+1)'($urandom_range(0, 10));
            loop_en  = $urandom_range(0, 1) == 1;
            idle_kc  = $urandom;
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            cyc();
        end
        rst = 0; cfg_we = 0; start = 0; stop = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
